exec_unit_pipe: RTL and testbench
=================================

Name: exec_unit_pipe

Overview:
- Parametrised successor to the single-cycle execution stage of the Tomasulo core.
- Accepts one dispatched op per cycle from the reservation stations and routes it to one of three units:
  - 1-cycle ALU for add/sub.
  - MUL_LAT-stage pipelined multiplier.
  - Iterative restoring divider.
- Completed results arbitrate onto one common data bus (CDB) broadcast that the ROB, register bank and reservation stations snoop.
- Adds valid/ready backpressure, multi-cycle latency, flush and divide-by-zero reporting.

Parameters:
- DATA_W, 8, operand width; results are 2*DATA_W wide.
- ROB_IDX_W, 3, ROB tag width.
- RS_IDX_W, 3, reservation-station slot index width.
- REG_IDX_W, 4, architectural destination register index width.
- MUL_LAT, 3, multiplier pipeline depth (>=1).

Ports:
- clk1  in  1  core clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  squash all in-flight ops (mispredict/exception recovery).
- in_valid  in  1  dispatch request.
- in_ready  out  1  dispatch accepted this cycle when in_valid && in_ready.
- in_func  in  4  0000 add, 0001 sub, 0010 mul, 0011 div, others illegal.
- in_rs1  in  DATA_W  operand 1.
- in_rs2  in  DATA_W  operand 2.
- in_rob  in  ROB_IDX_W  ROB tag.
- in_rd  in  REG_IDX_W  destination register.
- in_rs_idx  in  RS_IDX_W  issuing station slot.
- cdb_valid  out  1  broadcast valid.
- cdb_ready  in  1  consumer accepts broadcast.
- cdb_data  out  2*DATA_W  result.
- cdb_rob  out  ROB_IDX_W  tag of result.
- cdb_rd  out  REG_IDX_W  destination register.
- cdb_rs_idx  out  RS_IDX_W  station slot to free.
- cdb_unit  out  2  source unit: 0 ALU, 1 MUL, 2 DIV.
- cdb_exc  out  1  1 = divide-by-zero or illegal func.
- div_busy  out  1  divider occupied.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All valid bits cleared; divider returns to IDLE.
  - cdb_valid=0, cdb_data=0, cdb_rob=0, cdb_rd=0, cdb_rs_idx=0, cdb_unit=0, cdb_exc=0, div_busy=0.
  - Reset mid-operation discards every in-flight op; no broadcast follows.
- flush: same clearing effect as rst, but lower priority; rst wins if both are high. Dispatch in the flush cycle is ignored.
- Each unit ends in an output holding register (valid + payload).
- Arbitration and broadcast:
  - CDB grant priority when more than one holding register is valid: DIV > MUL > ALU.
  - A granted register clears on cdb_valid && cdb_ready.
  - CDB outputs are registered-stable: the payload must not change while cdb_valid=1 && cdb_ready=0.
- ALU (add/sub):
  - Result written to its holding register on the accept edge; visible on the CDB the next cycle (latency 1).
  - add/sub are zero-extended to 2*DATA_W. sub wraps modulo 2^DATA_W, then is zero-extended (e.g. 3-5 = 0x00FE for DATA_W=8).
  - Illegal func also takes the ALU path: data=0, cdb_exc=1.
- MUL:
  - Unsigned full-width product.
  - MUL_LAT stages plus the holding register: latency MUL_LAT cycles from accept to holding register when not stalled.
  - The whole pipeline advances only when the holding register is empty or is being granted this cycle; otherwise all stages hold.
- DIV:
  - FSM IDLE -> BUSY (DATA_W iterations, one quotient bit per cycle) -> DONE (result in holding register) -> IDLE on grant.
  - Accept only in IDLE; div_busy=1 in BUSY and DONE.
  - cdb_data = {remainder, quotient}.
  - Divisor 0: skip iteration and go straight to DONE next cycle with quotient all-ones, remainder = dividend, cdb_exc=1.
- in_ready is combinational on in_func:
  - add/sub/illegal: ALU holding register empty or being granted.
  - mul: MUL pipeline advancing.
  - div: divider IDLE.
  - in_ready=0 during rst or flush.
- Same-cycle events:
  - A new accept into a unit whose holding register is granted in the same cycle is legal; there are no bubbles.
  - The ALU may broadcast the same cycle a mul is accepted.
- Ordering: results may return out of program order; the ROB tag resolves it.

Decomposition:
- Shared package exec_pkg:
  - func code constants FUNC_ADD/SUB/MUL/DIV.
  - unit encoding UNIT_ALU/MUL/DIV.
  - divider state typedef.
- Sub-module div_iter: iterative restoring divider with start/busy/done, instantiated once.
- The multiplier pipeline and arbiter stay inline.

Test Plan (DATA_W=8, MUL_LAT=3):
- Reset and idle: rst=1 then 0, in_valid=0 -> cdb_valid=0, div_busy=0, all CDB fields 0.
- ALU path: add 0x7F+0x02, rob=5, rd=3, cdb_ready=1 -> next cycle cdb_valid=1, data=0x0081, rob=5, unit=0. Sub 3-5 -> data=0x00FE.
- MUL latency and backpressure:
  - 0x10*0x10 -> data=0x0100 exactly 3 cycles after accept.
  - Hold cdb_ready=0 -> payload stable, and a second mul is accepted only while the pipeline still has an empty stage.
- Priority collision: launch div 200/7, then time an add so both holding registers are valid together -> DIV broadcast first with data={0x04,0x1C}, then ALU.
- Divide-by-zero: 9/0 -> div_busy for 1 cycle, data={0x09,0xFF}, cdb_exc=1. Illegal func 0111 -> data=0, cdb_exc=1.
- Flush mid-divide: flush asserted 3 cycles into a div with a mul in flight -> no broadcast ever appears, div_busy=0 next cycle, in_ready=1 for all funcs.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared encodings for the execution stage: func codes, CDB source units, divider states.
package exec_pkg;

  localparam logic [3:0] FUNC_ADD = 4'b0000;
  localparam logic [3:0] FUNC_SUB = 4'b0001;
  localparam logic [3:0] FUNC_MUL = 4'b0010;
  localparam logic [3:0] FUNC_DIV = 4'b0011;

  localparam logic [1:0] UNIT_ALU = 2'd0;
  localparam logic [1:0] UNIT_MUL = 2'd1;
  localparam logic [1:0] UNIT_DIV = 2'd2;

  typedef logic [1:0] div_state_t;
  localparam div_state_t DIV_IDLE = 2'd0;
  localparam div_state_t DIV_BUSY = 2'd1;
  localparam div_state_t DIV_DONE = 2'd2;

endpackage

// File: rtl/div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, result held in DONE until acked.
module div_iter
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              clear,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              ack,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              dbz
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  div_state_t        state_q, state_d;
  logic [DATA_W-1:0] quo_q, rem_q, dvs_q, diff_c;
  logic [CNT_W-1:0]  cnt_q;
  logic              dbz_q;
  logic [DATA_W:0]   shift_c;
  logic              fits_c, last_c;

  // Trial subtraction of the shifted partial remainder.
  always_comb begin
    shift_c = {rem_q, quo_q[DATA_W-1]};
    fits_c  = shift_c >= {1'b0, dvs_q};
    diff_c  = shift_c[DATA_W-1:0] - dvs_q;
    last_c  = cnt_q == CNT_W'(DATA_W - 1);
  end

  always_ff @(posedge clk1) begin
    if (rst) state_q <= DIV_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (start)  state_d = (divisor == '0) ? DIV_DONE : DIV_BUSY;
      DIV_BUSY: if (last_c) state_d = DIV_DONE;
      DIV_DONE: if (ack)    state_d = DIV_IDLE;
      default:              state_d = DIV_IDLE;
    endcase
    if (clear) state_d = DIV_IDLE;
  end

  // Divide-by-zero preloads the final result so DONE follows immediately.
  always_ff @(posedge clk1) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      dbz_q <= 1'b0;
    end else if (state_q == DIV_IDLE && start) begin
      cnt_q <= '0;
      dvs_q <= divisor;
      dbz_q <= (divisor == '0);
      if (divisor == '0) begin
        quo_q <= '1;
        rem_q <= dividend;
      end else begin
        quo_q <= dividend;
        rem_q <= '0;
      end
    end else if (state_q == DIV_BUSY) begin
      rem_q <= fits_c ? diff_c : shift_c[DATA_W-1:0];
      quo_q <= {quo_q[DATA_W-2:0], fits_c};
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    busy      = state_q != DIV_IDLE;
    done      = state_q == DIV_DONE;
    quotient  = quo_q;
    remainder = rem_q;
    dbz       = dbz_q;
  end

endmodule

// File: rtl/exec_unit_pipe.sv
// Execution stage: ALU / pipelined MUL / iterative DIV feeding one arbitrated CDB broadcast.
module exec_unit_pipe
  import exec_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ROB_IDX_W = 3,
  parameter int unsigned RS_IDX_W  = 3,
  parameter int unsigned REG_IDX_W = 4,
  parameter int unsigned MUL_LAT   = 3
) (
  input  logic                   clk1,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_func,
  input  logic [DATA_W-1:0]      in_rs1,
  input  logic [DATA_W-1:0]      in_rs2,
  input  logic [ROB_IDX_W-1:0]   in_rob,
  input  logic [REG_IDX_W-1:0]   in_rd,
  input  logic [RS_IDX_W-1:0]    in_rs_idx,
  output logic                   cdb_valid,
  input  logic                   cdb_ready,
  output logic [2*DATA_W-1:0]    cdb_data,
  output logic [ROB_IDX_W-1:0]   cdb_rob,
  output logic [REG_IDX_W-1:0]   cdb_rd,
  output logic [RS_IDX_W-1:0]    cdb_rs_idx,
  output logic [1:0]             cdb_unit,
  output logic                   cdb_exc,
  output logic                   div_busy
);

  localparam int unsigned RES_W = 2 * DATA_W;
  localparam int unsigned TAG_W = ROB_IDX_W + REG_IDX_W + RS_IDX_W;

  logic              clr_c, is_mul_c, is_div_c;
  logic              acc_c, acc_alu_c, acc_mul_c, acc_div_c;
  logic [TAG_W-1:0]  in_tag_c;
  logic [DATA_W:0]   sum_c;
  logic [DATA_W-1:0] diff_c;
  logic [RES_W-1:0]  alu_res_c, prod_c;
  logic              alu_exc_c;

  logic              alu_v_q, alu_exc_q;
  logic [RES_W-1:0]  alu_data_q;
  logic [TAG_W-1:0]  alu_tag_q;

  // Last entry of the mul pipe is its holding register.
  logic [MUL_LAT-1:0] mul_v_q;
  logic [RES_W-1:0]   mul_data_q [MUL_LAT];
  logic [TAG_W-1:0]   mul_tag_q  [MUL_LAT];

  logic [TAG_W-1:0]  div_tag_q;
  logic              div_done, div_dbz;
  logic [DATA_W-1:0] div_quo, div_rem;

  logic              lock_v_q;
  logic [1:0]        lock_unit_q;
  logic              sel_v_c, grant_c, gnt_alu_c, gnt_mul_c, gnt_div_c;
  logic [1:0]        sel_c;
  logic [TAG_W-1:0]  sel_tag_c;
  logic              alu_free_c, mul_adv_c;

  always_comb begin
    clr_c     = rst || flush;
    is_mul_c  = in_func == FUNC_MUL;
    is_div_c  = in_func == FUNC_DIV;
    in_tag_c  = {in_rob, in_rd, in_rs_idx};
    sum_c     = {1'b0, in_rs1} + {1'b0, in_rs2};
    diff_c    = in_rs1 - in_rs2;
    prod_c    = RES_W'(in_rs1) * RES_W'(in_rs2);
    alu_res_c = '0;
    alu_exc_c = 1'b0;
    case (in_func)
      FUNC_ADD: alu_res_c = RES_W'(sum_c);
      FUNC_SUB: alu_res_c = RES_W'(diff_c);
      default:  alu_exc_c = 1'b1;
    endcase
  end

  // A stalled broadcast stays locked to its unit so the payload cannot switch under it.
  always_comb begin
    sel_v_c = 1'b1;
    sel_c   = UNIT_ALU;
    if (lock_v_q)                sel_c = lock_unit_q;
    else if (div_done)           sel_c = UNIT_DIV;
    else if (mul_v_q[MUL_LAT-1]) sel_c = UNIT_MUL;
    else if (!alu_v_q)           sel_v_c = 1'b0;

    cdb_data  = '0;
    cdb_exc   = 1'b0;
    sel_tag_c = '0;
    if (sel_v_c) begin
      case (sel_c)
        UNIT_DIV: begin
          cdb_data  = {div_rem, div_quo};
          cdb_exc   = div_dbz;
          sel_tag_c = div_tag_q;
        end
        UNIT_MUL: begin
          cdb_data  = mul_data_q[MUL_LAT-1];
          sel_tag_c = mul_tag_q[MUL_LAT-1];
        end
        default: begin
          cdb_data  = alu_data_q;
          cdb_exc   = alu_exc_q;
          sel_tag_c = alu_tag_q;
        end
      endcase
    end
    cdb_valid                        = sel_v_c;
    cdb_unit                         = sel_c;
    {cdb_rob, cdb_rd, cdb_rs_idx}    = sel_tag_c;

    grant_c   = sel_v_c && cdb_ready;
    gnt_alu_c = grant_c && (sel_c == UNIT_ALU);
    gnt_mul_c = grant_c && (sel_c == UNIT_MUL);
    gnt_div_c = grant_c && (sel_c == UNIT_DIV);
  end

  always_comb begin
    alu_free_c = !alu_v_q || gnt_alu_c;
    mul_adv_c  = !mul_v_q[MUL_LAT-1] || gnt_mul_c;
    in_ready   = 1'b0;
    if (!clr_c) begin
      if (is_mul_c)      in_ready = mul_adv_c;
      else if (is_div_c) in_ready = !div_busy;
      else               in_ready = alu_free_c;
    end
    acc_c     = in_valid && in_ready;
    acc_mul_c = acc_c && is_mul_c;
    acc_div_c = acc_c && is_div_c;
    acc_alu_c = acc_c && !is_mul_c && !is_div_c;
  end

  always_ff @(posedge clk1) begin
    if (clr_c) begin
      alu_v_q <= 1'b0;
    end else if (acc_alu_c) begin
      alu_v_q    <= 1'b1;
      alu_data_q <= alu_res_c;
      alu_exc_q  <= alu_exc_c;
      alu_tag_q  <= in_tag_c;
    end else if (gnt_alu_c) begin
      alu_v_q <= 1'b0;
    end
  end

  // Whole mul pipe moves in lockstep; it freezes while its holding register waits on the CDB.
  always_ff @(posedge clk1) begin
    if (clr_c) begin
      mul_v_q <= '0;
    end else if (mul_adv_c) begin
      mul_v_q[0]    <= acc_mul_c;
      mul_data_q[0] <= prod_c;
      mul_tag_q[0]  <= in_tag_c;
      for (int i = 1; i < int'(MUL_LAT); i++) begin
        mul_v_q[i]    <= mul_v_q[i-1];
        mul_data_q[i] <= mul_data_q[i-1];
        mul_tag_q[i]  <= mul_tag_q[i-1];
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (acc_div_c) div_tag_q <= in_tag_c;
  end

  always_ff @(posedge clk1) begin
    if (clr_c) begin
      lock_v_q    <= 1'b0;
      lock_unit_q <= UNIT_ALU;
    end else begin
      lock_v_q    <= sel_v_c && !cdb_ready;
      lock_unit_q <= sel_c;
    end
  end

  div_iter #(.DATA_W(DATA_W)) u_div (
    .clk1      (clk1),
    .rst       (rst),
    .clear     (flush),
    .start     (acc_div_c),
    .dividend  (in_rs1),
    .divisor   (in_rs2),
    .ack       (gnt_div_c),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem),
    .dbz       (div_dbz)
  );

endmodule

// File: tb/tb_exec_unit_pipe.sv
// Self-checking bench for exec_unit_pipe: vector table plus multi-cycle corner sequences.
module tb_exec_unit_pipe;
  import exec_pkg::*;

  logic        clk1 = 1'b0;
  logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, cdb_ready = 1'b0;
  logic        in_ready, cdb_valid, cdb_exc, div_busy;
  logic [3:0]  in_func = 4'h0;
  logic [7:0]  in_rs1 = 8'h0, in_rs2 = 8'h0;
  logic [2:0]  in_rob = 3'd0, in_rs_idx = 3'd0, cdb_rob, cdb_rs_idx;
  logic [3:0]  in_rd = 4'd0, cdb_rd;
  logic [15:0] cdb_data;
  logic [1:0]  cdb_unit;

  always #5 clk1 = ~clk1;

  exec_unit_pipe #(
    .DATA_W(8), .ROB_IDX_W(3), .RS_IDX_W(3), .REG_IDX_W(4), .MUL_LAT(3)
  ) dut (
    .clk1(clk1), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_func(in_func), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rob(in_rob), .in_rd(in_rd),
    .in_rs_idx(in_rs_idx), .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_data(cdb_data),
    .cdb_rob(cdb_rob), .cdb_rd(cdb_rd), .cdb_rs_idx(cdb_rs_idx), .cdb_unit(cdb_unit),
    .cdb_exc(cdb_exc), .div_busy(div_busy)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  rob;
    logic [3:0]  rd;
    logic [2:0]  rs;
    logic [1:0]  unit;
    logic        exc;
  } bcast_t;

  typedef struct {
    logic [3:0] func;
    logic [7:0] a;
    logic [7:0] b;
    int         lat;
    bcast_t     exp;
  } vec_t;

  int     n_chk = 0;
  int     n_pass = 0;
  bcast_t exp_q[$];
  bcast_t mon_exp, mon_act;
  vec_t   vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  function automatic bcast_t mkb(input logic [15:0] d, input logic [2:0] rob, input logic [3:0] rd,
                                 input logic [2:0] rs, input logic [1:0] u, input logic e);
    bcast_t b;
    b.data = d; b.rob = rob; b.rd = rd; b.rs = rs; b.unit = u; b.exc = e;
    return b;
  endfunction

  function automatic vec_t mk(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                              input logic [2:0] rob, input logic [3:0] rd, input logic [2:0] rs,
                              input int lat, input logic [15:0] d, input logic [1:0] u, input logic e);
    vec_t v;
    v.func = f; v.a = a; v.b = b; v.lat = lat;
    v.exp = mkb(d, rob, rd, rs, u, e);
    return v;
  endfunction

  // Drive one op, confirm it is accepted, and leave the bus idle after the accept edge.
  task automatic send(input string name, input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] rob, input logic [3:0] rd, input logic [2:0] rs);
    in_valid = 1'b1; in_func = f; in_rs1 = a; in_rs2 = b;
    in_rob = rob; in_rd = rd; in_rs_idx = rs;
    #1;
    check({"in_ready_", name}, 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check({"drain_", name}, 64'(exp_q.size()), 64'(0));
  endtask

  // Scoreboard: every CDB handshake must match the oldest expected broadcast.
  always @(negedge clk1) begin
    if (cdb_valid === 1'b1 && cdb_ready === 1'b1) begin
      mon_act = mkb(cdb_data, cdb_rob, cdb_rd, cdb_rs_idx, cdb_unit, cdb_exc);
      if (exp_q.size() == 0) begin
        check("unexpected_bcast", 64'(mon_act), 64'(0));
      end else begin
        mon_exp = exp_q.pop_front();
        check("bcast", 64'(mon_act), 64'(mon_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int nb;

    vecs[0]  = mk(FUNC_ADD, 8'h7F, 8'h02, 3'd5, 4'd3, 3'd1, 0, 16'h0081, UNIT_ALU, 1'b0);
    vecs[1]  = mk(FUNC_SUB, 8'h03, 8'h05, 3'd2, 4'd7, 3'd4, 0, 16'h00FE, UNIT_ALU, 1'b0);
    vecs[2]  = mk(FUNC_SUB, 8'h00, 8'h01, 3'd1, 4'd1, 3'd2, 0, 16'h00FF, UNIT_ALU, 1'b0);
    vecs[3]  = mk(FUNC_MUL, 8'h10, 8'h10, 3'd3, 4'd4, 3'd5, 2, 16'h0100, UNIT_MUL, 1'b0);
    vecs[4]  = mk(FUNC_MUL, 8'hFF, 8'hFF, 3'd6, 4'hE, 3'd6, 2, 16'hFE01, UNIT_MUL, 1'b0);
    vecs[5]  = mk(FUNC_MUL, 8'h00, 8'hAB, 3'd0, 4'd2, 3'd7, 2, 16'h0000, UNIT_MUL, 1'b0);
    vecs[6]  = mk(FUNC_DIV, 8'hC8, 8'h07, 3'd4, 4'd9, 3'd3, 8, 16'h041C, UNIT_DIV, 1'b0);
    vecs[7]  = mk(FUNC_DIV, 8'h09, 8'h00, 3'd7, 4'd5, 3'd0, 0, 16'h09FF, UNIT_DIV, 1'b1);
    vecs[8]  = mk(FUNC_DIV, 8'hFF, 8'h01, 3'd2, 4'hA, 3'd1, 8, 16'h00FF, UNIT_DIV, 1'b0);
    vecs[9]  = mk(FUNC_DIV, 8'h05, 8'h09, 3'd5, 4'hB, 3'd2, 8, 16'h0500, UNIT_DIV, 1'b0);
    vecs[10] = mk(4'b0111,  8'hAA, 8'h55, 3'd6, 4'hC, 3'd3, 0, 16'h0000, UNIT_ALU, 1'b1);
    vecs[11] = mk(4'b1111,  8'h01, 8'h01, 3'd1, 4'hF, 3'd6, 0, 16'h0000, UNIT_ALU, 1'b1);
    vecs[12] = mk(FUNC_ADD, 8'h12, 8'h34, 3'd7, 4'd6, 3'd5, 0, 16'h0046, UNIT_ALU, 1'b0);

    // Reset and idle.
    rst = 1'b1;
    tick();
    tick();
    check("in_ready_during_rst", 64'(in_ready), 64'(0));
    check("rst_cdb_valid", 64'(cdb_valid), 64'(0));
    check("rst_div_busy", 64'(div_busy), 64'(0));
    check("rst_cdb_fields", 64'({cdb_data, cdb_rob, cdb_rd, cdb_rs_idx, cdb_unit, cdb_exc}), 64'(0));
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 64'(in_ready), 64'(1));
    tick();
    check("idle_cdb_valid", 64'(cdb_valid), 64'(0));
    cdb_ready = 1'b1;

    // Table of single ops, each run to completion on an idle unit.
    foreach (vecs[i]) begin
      exp_q.push_back(vecs[i].exp);
      send($sformatf("vec%0d", i), vecs[i].func, vecs[i].a, vecs[i].b,
           vecs[i].exp.rob, vecs[i].exp.rd, vecs[i].exp.rs);
      n = 0;
      while (cdb_valid !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      check($sformatf("latency_vec%0d", i), 64'(n), 64'(vecs[i].lat));
      drain($sformatf("vec%0d", i));
    end

    // Backpressure: ALU broadcast stalls, mul fills its holding register behind it.
    cdb_ready = 1'b0;
    exp_q.push_back(mkb(16'h000B, 3'd2, 4'd2, 3'd2, UNIT_ALU, 1'b0));
    exp_q.push_back(mkb(16'h0100, 3'd1, 4'd1, 3'd1, UNIT_MUL, 1'b0));
    exp_q.push_back(mkb(16'h000F, 3'd3, 4'd3, 3'd3, UNIT_MUL, 1'b0));
    send("bp_mul_a", FUNC_MUL, 8'h10, 8'h10, 3'd1, 4'd1, 3'd1);
    send("bp_add", FUNC_ADD, 8'h05, 8'h06, 3'd2, 4'd2, 3'd2);
    check("bp_alu_shown", 64'({cdb_valid, cdb_unit, cdb_data}), 64'({1'b1, UNIT_ALU, 16'h000B}));
    send("bp_mul_b", FUNC_MUL, 8'h03, 8'h05, 3'd3, 4'd3, 3'd3);
    in_func = FUNC_MUL;
    #1;
    check("bp_mul_stalled_ready", 64'(in_ready), 64'(0));
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("bp_stable_%0d", k), 64'({cdb_valid, cdb_unit, cdb_data, cdb_rob}),
            64'({1'b1, UNIT_ALU, 16'h000B, 3'd2}));
    end
    cdb_ready = 1'b1;
    drain("backpressure");

    // Collision: add lands in the ALU register the same edge the divider finishes.
    exp_q.push_back(mkb(16'h041C, 3'd3, 4'd8, 3'd2, UNIT_DIV, 1'b0));
    exp_q.push_back(mkb(16'h0003, 3'd4, 4'd9, 3'd6, UNIT_ALU, 1'b0));
    send("col_div", FUNC_DIV, 8'd200, 8'd7, 3'd3, 4'd8, 3'd2);
    repeat (7) tick();
    send("col_add", FUNC_ADD, 8'h01, 8'h02, 3'd4, 4'd9, 3'd6);
    check("col_first_unit", 64'({cdb_valid, cdb_unit}), 64'({1'b1, UNIT_DIV}));
    drain("collision");

    // Divide-by-zero occupies the divider for exactly one cycle.
    exp_q.push_back(mkb(16'h09FF, 3'd0, 4'd1, 3'd1, UNIT_DIV, 1'b1));
    send("dbz", FUNC_DIV, 8'h09, 8'h00, 3'd0, 4'd1, 3'd1);
    check("dbz_busy_1", 64'(div_busy), 64'(1));
    tick();
    check("dbz_busy_0", 64'(div_busy), 64'(0));
    drain("dbz");

    // Flush mid-divide with a mul in flight.
    send("fl_div", FUNC_DIV, 8'd100, 8'd3, 3'd5, 4'd5, 3'd5);
    send("fl_mul", FUNC_MUL, 8'h05, 8'h05, 3'd6, 4'd6, 3'd6);
    tick();
    flush = 1'b1;
    in_valid = 1'b1; in_func = FUNC_ADD; in_rs1 = 8'h01; in_rs2 = 8'h01;
    #1;
    check("in_ready_during_flush", 64'(in_ready), 64'(0));
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_div_busy", 64'(div_busy), 64'(0));
    check("flush_cdb_valid", 64'(cdb_valid), 64'(0));
    for (int f = 0; f < 4; f++) begin
      in_func = 4'(f);
      #1;
      check($sformatf("flush_in_ready_f%0d", f), 64'(in_ready), 64'(1));
    end
    nb = 0;
    repeat (20) begin
      tick();
      if (cdb_valid !== 1'b0) nb++;
    end
    check("flush_no_bcast", 64'(nb), 64'(0));

    // Reset mid-operation discards everything in flight.
    send("rs_div", FUNC_DIV, 8'h50, 8'h03, 3'd1, 4'd2, 3'd3);
    send("rs_mul", FUNC_MUL, 8'h07, 8'h07, 3'd2, 4'd3, 3'd4);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_div_busy", 64'(div_busy), 64'(0));
    check("midrst_cdb_valid", 64'(cdb_valid), 64'(0));
    nb = 0;
    repeat (15) begin
      tick();
      if (cdb_valid !== 1'b0) nb++;
    end
    check("midrst_no_bcast", 64'(nb), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
